// File: rtl/obb_integrator_bank.sv
// Register bank of N_BODIES oriented bounding boxes: accumulates solver impulses
// and, on step_start, applies them and integrates each body in turn (IMP then INT).
module obb_integrator_bank #(
   parameter int N_BODIES  = 4,
   parameter int W         = 32,
   parameter int FRAC      = 24,
   parameter int IM_W      = 16,
   parameter int IM_FRAC   = 12,
   parameter int A_W       = 11,
   parameter int TWO_PI    = 804,
   parameter int ARENA_MIN = 0,
   parameter int ARENA_MAX = 64,
   localparam int IDW      = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  step_start,
   output logic                  step_busy,
   output logic                  step_done,
   input  logic                  imp_valid,
   output logic                  imp_ready,
   input  logic [IDW-1:0]        imp_id,
   input  logic signed [W-1:0]   imp_x,
   input  logic signed [W-1:0]   imp_y,
   input  logic signed [A_W-1:0] imp_rot,
   input  logic                  cfg_we,
   input  logic [IDW-1:0]        cfg_id,
   input  logic signed [W-1:0]   cfg_pos_x,
   input  logic signed [W-1:0]   cfg_pos_y,
   input  logic signed [W-1:0]   cfg_vel_x,
   input  logic signed [W-1:0]   cfg_vel_y,
   input  logic signed [A_W-1:0] cfg_angle,
   input  logic signed [A_W-1:0] cfg_omega,
   input  logic [IM_W-1:0]       cfg_inv_mass,
   input  logic [IDW-1:0]        rd_id,
   output logic signed [W-1:0]   rd_pos_x,
   output logic signed [W-1:0]   rd_pos_y,
   output logic signed [W-1:0]   rd_vel_x,
   output logic signed [W-1:0]   rd_vel_y,
   output logic signed [A_W-1:0] rd_angle,
   output logic signed [A_W-1:0] rd_omega
);

   localparam int PW = W + IM_W + 1;
   localparam logic signed [W-1:0]   P_MAX  = W'(ARENA_MAX) << FRAC;
   localparam logic signed [W-1:0]   P_MIN  = W'(ARENA_MIN) << FRAC;
   localparam logic signed [A_W:0]   TP     = (A_W+1)'(TWO_PI);
   localparam logic [IDW-1:0]        K_LAST = IDW'(N_BODIES - 1);
   localparam logic signed [W-1:0]   W_MAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]   W_MIN  = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [A_W-1:0] A_MAX  = {1'b0, {(A_W-1){1'b1}}};
   localparam logic signed [A_W-1:0] A_MIN  = {1'b1, {(A_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_IMP, S_INT} state_t;

   state_t         state;
   logic [IDW-1:0] k;

   logic signed [W-1:0]   pos_x_q [N_BODIES];
   logic signed [W-1:0]   pos_y_q [N_BODIES];
   logic signed [W-1:0]   vel_x_q [N_BODIES];
   logic signed [W-1:0]   vel_y_q [N_BODIES];
   logic signed [A_W-1:0] angle_q [N_BODIES];
   logic signed [A_W-1:0] omega_q [N_BODIES];
   logic [IM_W-1:0]       inv_mass_q [N_BODIES];
   logic signed [W-1:0]   acc_x_q [N_BODIES];
   logic signed [W-1:0]   acc_y_q [N_BODIES];
   logic signed [A_W-1:0] acc_rot_q [N_BODIES];

   function automatic logic signed [W-1:0] sat_add_w(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
      logic [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1]) return s[W] ? W_MIN : W_MAX;
      return s[W-1:0];
   endfunction

   function automatic logic signed [A_W-1:0] sat_add_a(input logic signed [A_W-1:0] a,
                                                       input logic signed [A_W-1:0] b);
      logic [A_W:0] s;
      s = {a[A_W-1], a} + {b[A_W-1], b};
      if (s[A_W] != s[A_W-1]) return s[A_W] ? A_MIN : A_MAX;
      return s[A_W-1:0];
   endfunction

   // vel + (acc * inv_mass) >>> IM_FRAC at full width, clamped back to W bits.
   function automatic logic signed [W-1:0] apply_imp(input logic signed [W-1:0] v,
                                                     input logic signed [W-1:0] acc,
                                                     input logic [IM_W-1:0]     im);
      logic signed [PW-1:0] ax, bx, prod, sh;
      logic [PW:0]          s;
      ax   = {{(IM_W+1){acc[W-1]}}, acc};
      bx   = {{(W+1){1'b0}}, im};
      prod = ax * bx;
      sh   = prod >>> IM_FRAC;
      s    = {sh[PW-1], sh} + {{(PW+1-W){v[W-1]}}, v};
      if (s[PW:W-1] == '0 || s[PW:W-1] == '1) return s[W-1:0];
      return s[PW] ? W_MIN : W_MAX;
   endfunction

   // Returns {new_pos, new_vel}; reflects only when crossing a wall while moving outward.
   function automatic logic [2*W-1:0] bounce(input logic signed [W-1:0] p,
                                             input logic signed [W-1:0] v);
      logic signed [W-1:0] pn;
      pn = p + v;
      if (pn > P_MAX && !v[W-1] && v != '0) return {P_MAX, -v};
      if (pn < P_MIN && v[W-1])              return {P_MIN, -v};
      return {pn, v};
   endfunction

   function automatic logic signed [A_W-1:0] wrap_angle(input logic signed [A_W-1:0] a,
                                                        input logic signed [A_W-1:0] om);
      logic signed [A_W:0] s;
      s = {a[A_W-1], a} + {om[A_W-1], om};
      if (s >= TP)     s = s - TP;
      else if (s[A_W]) s = s + TP;
      return s[A_W-1:0];
   endfunction

   assign step_busy = (state != S_IDLE);
   assign imp_ready = (state == S_IDLE) && !step_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         k         <= '0;
         step_done <= 1'b0;
         rd_pos_x  <= '0;
         rd_pos_y  <= '0;
         rd_vel_x  <= '0;
         rd_vel_y  <= '0;
         rd_angle  <= '0;
         rd_omega  <= '0;
         for (int i = 0; i < N_BODIES; i++) begin
            pos_x_q[i]    <= '0;
            pos_y_q[i]    <= '0;
            vel_x_q[i]    <= '0;
            vel_y_q[i]    <= '0;
            angle_q[i]    <= '0;
            omega_q[i]    <= '0;
            inv_mass_q[i] <= '0;
            acc_x_q[i]    <= '0;
            acc_y_q[i]    <= '0;
            acc_rot_q[i]  <= '0;
         end
      end else begin
         step_done <= 1'b0;
         rd_pos_x  <= pos_x_q[rd_id];
         rd_pos_y  <= pos_y_q[rd_id];
         rd_vel_x  <= vel_x_q[rd_id];
         rd_vel_y  <= vel_y_q[rd_id];
         rd_angle  <= angle_q[rd_id];
         rd_omega  <= omega_q[rd_id];
         case (state)
            S_IDLE: begin
               if (step_start) begin
                  k     <= '0;
                  state <= S_IMP;
               end else begin
                  if (cfg_we) begin
                     pos_x_q[cfg_id]    <= cfg_pos_x;
                     pos_y_q[cfg_id]    <= cfg_pos_y;
                     vel_x_q[cfg_id]    <= cfg_vel_x;
                     vel_y_q[cfg_id]    <= cfg_vel_y;
                     angle_q[cfg_id]    <= cfg_angle;
                     omega_q[cfg_id]    <= cfg_omega;
                     inv_mass_q[cfg_id] <= cfg_inv_mass;
                  end
                  if (imp_valid) begin
                     acc_x_q[imp_id]   <= sat_add_w(acc_x_q[imp_id], imp_x);
                     acc_y_q[imp_id]   <= sat_add_w(acc_y_q[imp_id], imp_y);
                     acc_rot_q[imp_id] <= sat_add_a(acc_rot_q[imp_id], imp_rot);
                  end
               end
            end
            S_IMP: begin
               vel_x_q[k]   <= apply_imp(vel_x_q[k], acc_x_q[k], inv_mass_q[k]);
               vel_y_q[k]   <= apply_imp(vel_y_q[k], acc_y_q[k], inv_mass_q[k]);
               omega_q[k]   <= sat_add_a(omega_q[k], acc_rot_q[k]);
               acc_x_q[k]   <= '0;
               acc_y_q[k]   <= '0;
               acc_rot_q[k] <= '0;
               state        <= S_INT;
            end
            S_INT: begin
               {pos_x_q[k], vel_x_q[k]} <= bounce(pos_x_q[k], vel_x_q[k]);
               {pos_y_q[k], vel_y_q[k]} <= bounce(pos_y_q[k], vel_y_q[k]);
               angle_q[k] <= wrap_angle(angle_q[k], omega_q[k]);
               if (k == K_LAST) begin
                  state     <= S_IDLE;
                  step_done <= 1'b1;
               end else begin
                  k     <= k + 1'b1;
                  state <= S_IMP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obb_integrator_bank.sv
// Directed bench for obb_integrator_bank: free motion, impulses, wall bounce,
// angle wrap, handshake corner cases and reset mid-step.
module tb_obb_integrator_bank;

   localparam int W    = 32;
   localparam int A_W  = 11;
   localparam int IM_W = 16;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           step_start, step_busy, step_done;
   logic           imp_valid, imp_ready;
   logic [IDW-1:0] imp_id;
   logic [W-1:0]   imp_x, imp_y;
   logic [A_W-1:0] imp_rot;
   logic           cfg_we;
   logic [IDW-1:0] cfg_id;
   logic [W-1:0]   cfg_pos_x, cfg_pos_y, cfg_vel_x, cfg_vel_y;
   logic [A_W-1:0] cfg_angle, cfg_omega;
   logic [IM_W-1:0] cfg_inv_mass;
   logic [IDW-1:0] rd_id;
   logic [W-1:0]   rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y;
   logic [A_W-1:0] rd_angle, rd_omega;

   obb_integrator_bank dut (
      .clk(clk), .rst_n(rst_n),
      .step_start(step_start), .step_busy(step_busy), .step_done(step_done),
      .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_id(imp_id),
      .imp_x(imp_x), .imp_y(imp_y), .imp_rot(imp_rot),
      .cfg_we(cfg_we), .cfg_id(cfg_id),
      .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
      .cfg_vel_x(cfg_vel_x), .cfg_vel_y(cfg_vel_y),
      .cfg_angle(cfg_angle), .cfg_omega(cfg_omega), .cfg_inv_mass(cfg_inv_mass),
      .rd_id(rd_id),
      .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y),
      .rd_vel_x(rd_vel_x), .rd_vel_y(rd_vel_y),
      .rd_angle(rd_angle), .rd_omega(rd_omega)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_body(input logic [IDW-1:0] id, input logic [W-1:0] px, py, vx, vy,
                           input logic [A_W-1:0] ang, om, input logic [IM_W-1:0] im);
      cfg_id = id; cfg_pos_x = px; cfg_pos_y = py; cfg_vel_x = vx; cfg_vel_y = vy;
      cfg_angle = ang; cfg_omega = om; cfg_inv_mass = im;
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic read_body(input logic [IDW-1:0] id);
      rd_id = id;
      tick();
   endtask

   task automatic send_imp(input logic [IDW-1:0] id, input logic [W-1:0] x, y,
                           input logic [A_W-1:0] rot);
      int n;
      imp_id = id; imp_x = x; imp_y = y; imp_rot = rot;
      imp_valid = 1'b1;
      n = 0;
      while (!imp_ready && n < 40) begin
         tick();
         n++;
      end
      chk("imp_accept_wait", 64'(n < 40), 64'd1);
      tick();
      imp_valid = 1'b0;
   endtask

   // Pulses step_start (optionally with a coincident impulse offer) and times step_done.
   task automatic run_step(input string tag, input bit with_imp);
      int n;
      bit ready_seen;
      step_start = 1'b1;
      if (with_imp) begin
         imp_id = 2'd3; imp_x = 32'h0100_0000; imp_y = '0; imp_rot = '0;
         imp_valid = 1'b1;
      end
      tick();
      step_start = 1'b0;
      imp_valid  = 1'b0;
      chk({tag, "_busy_rise"}, 64'(step_busy), 64'd1);
      n = 1;
      ready_seen = 1'b0;
      while (!step_done && n < 40) begin
         if (imp_ready) ready_seen = 1'b1;
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd9);
      chk({tag, "_ready_low"}, 64'(ready_seen), 64'd0);
      chk({tag, "_busy_fall"}, 64'(step_busy), 64'd0);
   endtask

   initial begin
      int n;
      bit ready_seen, done_seen;
      rst_n = 1'b0;
      step_start = 1'b0; imp_valid = 1'b0; imp_id = '0; imp_x = '0; imp_y = '0; imp_rot = '0;
      cfg_we = 1'b0; cfg_id = '0; cfg_pos_x = '0; cfg_pos_y = '0; cfg_vel_x = '0; cfg_vel_y = '0;
      cfg_angle = '0; cfg_omega = '0; cfg_inv_mass = '0; rd_id = '0;

      tick();
      tick();
      chk("rst_busy", 64'(step_busy), 64'd0);
      chk("rst_done", 64'(step_done), 64'd0);
      chk("rst_pos_x", 64'(rd_pos_x), 64'd0);
      chk("rst_angle", 64'(rd_angle), 64'd0);
      chk("rst_ready", 64'(imp_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      // Free motion: body0 at (10,10) moving +1.0 in x.
      cfg_body(2'd0, 32'h0A00_0000, 32'h0A00_0000, 32'h0100_0000, '0, '0, '0, '0);
      run_step("free", 1'b0);
      read_body(2'd0);
      chk("free_pos_x", 64'(rd_pos_x), 64'h0B00_0000);
      chk("free_pos_y", 64'(rd_pos_y), 64'h0A00_0000);
      chk("free_vel_x", 64'(rd_vel_x), 64'h0100_0000);

      // Two (2.0,0) impulses on body1 with inv_mass 0.5 -> dv = 2.0.
      cfg_body(2'd1, 32'h0500_0000, 32'h0500_0000, '0, '0, '0, '0, 16'h0800);
      send_imp(2'd1, 32'h0200_0000, '0, '0);
      send_imp(2'd1, 32'h0200_0000, '0, '0);
      run_step("imp1", 1'b0);
      read_body(2'd1);
      chk("imp_vel_x", 64'(rd_vel_x), 64'h0200_0000);
      chk("imp_pos_x", 64'(rd_pos_x), 64'h0700_0000);
      chk("imp_vel_y", 64'(rd_vel_y), 64'd0);
      run_step("imp2", 1'b0);
      read_body(2'd1);
      chk("imp2_vel_x", 64'(rd_vel_x), 64'h0200_0000);
      chk("imp2_pos_x", 64'(rd_pos_x), 64'h0900_0000);

      // Wall bounce at ARENA_MAX, then no second reflection.
      cfg_body(2'd2, 32'h3F80_0000, 32'h0100_0000, 32'h0100_0000, '0, '0, '0, '0);
      run_step("bnc1", 1'b0);
      read_body(2'd2);
      chk("bnc1_pos_x", 64'(rd_pos_x), 64'h4000_0000);
      chk("bnc1_vel_x", 64'(rd_vel_x), 64'hFF00_0000);
      chk("bnc1_pos_y", 64'(rd_pos_y), 64'h0100_0000);
      run_step("bnc2", 1'b0);
      read_body(2'd2);
      chk("bnc2_pos_x", 64'(rd_pos_x), 64'h3F00_0000);
      chk("bnc2_vel_x", 64'(rd_vel_x), 64'hFF00_0000);

      // Angle wrap cases on body3.
      cfg_body(2'd3, '0, '0, '0, '0, 11'd800, 11'd10, '0);
      run_step("ang1", 1'b0);
      read_body(2'd3);
      chk("ang_800_p10", 64'(rd_angle), 64'd6);
      cfg_body(2'd3, '0, '0, '0, '0, 11'd5, 11'h7F6, '0);
      run_step("ang2", 1'b0);
      read_body(2'd3);
      chk("ang_5_m10", 64'(rd_angle), 64'd799);
      chk("ang_5_m10_omega", 64'(rd_omega), 64'h7F6);
      cfg_body(2'd3, '0, '0, '0, '0, 11'd794, 11'd10, '0);
      run_step("ang3", 1'b0);
      read_body(2'd3);
      chk("ang_794_p10", 64'(rd_angle), 64'd0);

      // Impulse held through a busy window; step_start and cfg_we mid-step ignored.
      cfg_body(2'd3, '0, '0, '0, '0, '0, '0, 16'h1000);
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      imp_id = 2'd3; imp_x = 32'h0100_0000; imp_y = '0; imp_rot = 11'd3;
      imp_valid = 1'b1;
      cfg_id = 2'd3; cfg_vel_x = 32'h0500_0000;
      n = 1;
      ready_seen = 1'b0;
      while (!step_done && n < 40) begin
         if (imp_ready) ready_seen = 1'b1;
         step_start = (n == 3);
         cfg_we     = (n == 3);
         tick();
         n++;
      end
      step_start = 1'b0;
      cfg_we = 1'b0;
      chk("hs_latency", 64'(n), 64'd9);
      chk("hs_ready_low", 64'(ready_seen), 64'd0);
      chk("hs_ready_idle", 64'(imp_ready), 64'd1);
      tick();
      imp_valid = 1'b0;
      chk("hs_no_queued_step", 64'(step_busy), 64'd0);
      run_step("hs_apply", 1'b0);
      read_body(2'd3);
      chk("hs_vel_x", 64'(rd_vel_x), 64'h0100_0000);
      chk("hs_pos_x", 64'(rd_pos_x), 64'h0100_0000);
      chk("hs_omega", 64'(rd_omega), 64'd3);
      chk("hs_angle", 64'(rd_angle), 64'd3);

      // Impulse offered together with step_start must be dropped.
      run_step("coinc", 1'b1);
      read_body(2'd3);
      chk("coinc_vel_x", 64'(rd_vel_x), 64'h0100_0000);
      chk("coinc_pos_x", 64'(rd_pos_x), 64'h0200_0000);
      chk("coinc_angle", 64'(rd_angle), 64'd6);

      // Reset asserted three cycles into a step.
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", 64'(step_busy), 64'd0);
      chk("rstmid_pos_x", 64'(rd_pos_x), 64'd0);
      chk("rstmid_vel_x", 64'(rd_vel_x), 64'd0);
      chk("rstmid_angle", 64'(rd_angle), 64'd0);
      done_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) rst_n = 1'b1;
         tick();
         if (step_done) done_seen = 1'b1;
      end
      chk("rstmid_no_done", 64'(done_seen), 64'd0);
      chk("rstmid_busy_after", 64'(step_busy), 64'd0);
      read_body(2'd0);
      chk("rstmid_b0_pos_x", 64'(rd_pos_x), 64'd0);
      read_body(2'd3);
      chk("rstmid_b3_omega", 64'(rd_omega), 64'd0);
      chk("rstmid_ready", 64'(imp_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/obb_integrator_bank.md
# obb_integrator_bank

Multi-body successor to the single-OBB next-state updater. It holds the dynamic state of `N_BODIES` oriented bounding boxes in registers and accepts queued impulses from the contact solver through a valid/ready port. On each `step_start` it sequentially applies the accumulated impulses and integrates position and angle for every body. It sits between the contact/impulse solver and the renderer: the solver pushes impulses, the frame controller pulses `step_start`, and the renderer reads state back.

## Interface

Parameters:
- `N_BODIES`, 4: number of bodies; id width `IDW = max(1, $clog2(N_BODIES))`.
- `W`, 32: width of pos, vel and impulse (signed).
- `FRAC`, 24: fraction bits shared by pos, vel and impulse.
- `IM_W`, 16: inv_mass width (unsigned).
- `IM_FRAC`, 12: inv_mass fraction bits.
- `A_W`, 11: angle, omega and rotational-impulse width (signed, 7 fraction bits).
- `TWO_PI`, 804: 2π in angle format (round(2π·128)).
- `ARENA_MIN`, 0: lower wall in integer units; applies to both axes.
- `ARENA_MAX`, 64: upper wall in integer units; applies to both axes.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `step_start` in 1: one-cycle request to run one integration step.
- `step_busy` out 1: high while a step is running.
- `step_done` out 1: one-cycle pulse when a step completes.
- `imp_valid` in 1: impulse offer.
- `imp_ready` out 1: impulse accept.
- `imp_id` in IDW: target body.
- `imp_x`, `imp_y` in W: linear impulse.
- `imp_rot` in A_W: rotational impulse.
- `cfg_we` in 1: state write strobe.
- `cfg_id` in IDW: body to write.
- `cfg_pos_x`, `cfg_pos_y`, `cfg_vel_x`, `cfg_vel_y` in W: state write data.
- `cfg_angle`, `cfg_omega` in A_W: state write data.
- `cfg_inv_mass` in IM_W: state write data.
- `rd_id` in IDW: read select.
- `rd_pos_x`, `rd_pos_y`, `rd_vel_x`, `rd_vel_y` out W: registered read data.
- `rd_angle`, `rd_omega` out A_W: registered read data.

## Operation

- Per body, the block stores pos, vel, angle, omega and inv_mass, plus an impulse accumulator (x, y, rot). All of these reset to 0.
- States are IDLE, IMP and INT, with body index `k`.
  - IDLE: when `step_start` is seen, set `k=0` and go to IMP.
  - IMP: apply body `k`'s accumulated impulse, then go to INT.
  - INT: integrate body `k`. If `k` is the last body, go to IDLE and pulse `step_done`; otherwise increment `k` and go to IMP.
- `step_start` while busy is ignored. It is not queued.
- `imp_ready = (state==IDLE) && !step_start`. On a handshake, the impulse is added into body `imp_id`'s accumulator with signed saturation to W / A_W bits. Repeated impulses accumulate.
- In the IMP cycle for body `k`:
  - `vel += (acc * inv_mass) >>> IM_FRAC`, using a full-width product, an arithmetic shift and saturation to W.
  - `omega += acc_rot`, with saturation.
  - The accumulator for body `k` is cleared in the same cycle.
- In the INT cycle for body `k`, with `p' = pos + vel` (wrapping add), per axis:
  - If `p' > ARENA_MAX<<FRAC` and `vel > 0`: set `pos = ARENA_MAX<<FRAC` and `vel = -vel`.
  - If `p' < ARENA_MIN<<FRAC` and `vel < 0`: set `pos = ARENA_MIN<<FRAC` and `vel = -vel`.
  - Otherwise set `pos = p'`.
  - A body already outside the arena but moving inward is not re-reflected.
- Angle in the INT cycle: `a' = angle + omega`. If `a' >= TWO_PI`, use `a' - TWO_PI`; if `a' < 0`, use `a' + TWO_PI`; otherwise use `a'`. The stored angle is always in [0, TWO_PI). Callers must keep `|omega| < TWO_PI`.
- `cfg_we` takes effect only in IDLE with `step_start` low; otherwise it is ignored. A cfg write does not clear the accumulator.
- `rd_*` is registered from `rd_id` every cycle, including during a step, and reflects the stored state as of the previous edge.

## Timing

- The step takes exactly 2·N_BODIES cycles in IMP/INT.
  - `step_busy` rises on the edge after `step_start`.
  - `step_done` pulses with `step_busy` falling; this is 2·N_BODIES+1 edges after `step_start` is sampled.
- Read latency is 1 cycle.
- Reset values: all outputs are 0, except `imp_ready`, which is 1 whenever `step_start` is low.
- Asserting `rst_n` low mid-step aborts immediately. All state and accumulators are zeroed and there is no `step_done`.

## Test plan

- **Free motion** (N=4): body0 pos (10.0, 10.0) = 0x0A00_0000, vel (1.0, 0); step → pos_x = 11.0 (0x0B00_0000), pos_y unchanged, `step_done` 9 cycles after `step_start`.
- **Impulse accumulation:** two impulses (2.0, 0) to body1 with inv_mass 0x0800 (0.5), vel 0; step → vel_x = 2.0, pos_x increases by 2.0, accumulator 0 afterwards; a second step changes vel by 0.
- **Wall bounce:** body2 pos_x 63.5, vel_x +1.0; step → pos_x = 64.0, vel_x = −1.0. Next step → pos_x = 63.0 with no second reflection.
- **Angle wrap:**
  - angle 800, omega 10 → angle 6.
  - angle 5, omega −10 → angle 799.
  - angle 794, omega 10 → angle 0.
- **Handshake:**
  - `imp_ready` = 0 for the whole busy window.
  - `imp_valid` held during busy is accepted on the first IDLE cycle.
  - `step_start` and `cfg_we` while busy have no effect.
  - `imp_valid` coincident with `step_start` is not accepted.
- **Reset mid-step:** `rst_n` low at cycle 3 of a step → all `rd_*` read 0, `step_busy` 0, and no `step_done` pulse.
